// File: rtl/arb_pkg.sv
// Shared constants and helpers for the request queue and single_cycle_arbiter.
package arb_pkg;

  localparam int ARB_N     = 16;
  localparam int ARB_CNT_W = 4;

  // 1 when vec has zero or exactly one bit set.
  function automatic logic onehot0_check(input logic [ARB_N-1:0] vec);
    return (vec & (vec - {{(ARB_N-1){1'b0}}, 1'b1})) == '0;
  endfunction

endpackage

// File: rtl/arb_req_queue_if.sv
// Request/grant bus between the requestors, the pending-request queue and the arbiter.
interface arb_req_queue_if
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int CNT_W = ARB_CNT_W
);

  logic [N-1:0]       push_i;
  logic [N-1:0]       gnt_i;
  logic [N-1:0]       req_o;
  logic [N-1:0]       full_o;
  logic [N*CNT_W-1:0] cnt_o;
  logic [N-1:0]       overflow_o;
  logic               gnt_err_o;
  logic               idle_o;

  modport master (
    output push_i, gnt_i,
    input  req_o, full_o, cnt_o, overflow_o, gnt_err_o, idle_o
  );

  modport slave (
    input  push_i, gnt_i,
    output req_o, full_o, cnt_o, overflow_o, gnt_err_o, idle_o
  );

endinterface

// File: rtl/arb_req_counter.sv
// One lane of pending-request tracking: saturating up/down counter with sticky overflow.
module arb_req_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             gnt,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             overflow,
  output logic             bad_gnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             dec;
  logic             inc;
  logic             drop;

  // A grant frees a slot in the same cycle, so a push on a full lane is kept when granted.
  assign full    = (cnt_q == CNT_MAX);
  assign dec     = gnt && (cnt_q != '0);
  assign inc     = push && (!full || dec);
  assign drop    = push && !inc;
  assign bad_gnt = gnt && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (inc && !dec) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign cnt      = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/arb_req_queue.sv
// Per-requestor pending-request tracker feeding single_cycle_arbiter; every output is
// decoded from registered state.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int CNT_W = ARB_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  arb_req_queue_if.slave  bus
);

  logic [CNT_W-1:0] cnt_lane [N];
  logic [N-1:0]     full;
  logic [N-1:0]     overflow;
  logic [N-1:0]     bad_gnt;
  logic [N-1:0]     req;
  logic             multi_gnt;
  logic             gnt_err_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    arb_req_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .push     (bus.push_i[k]),
      .gnt      (bus.gnt_i[k]),
      .cnt      (cnt_lane[k]),
      .full     (full[k]),
      .overflow (overflow[k]),
      .bad_gnt  (bad_gnt[k])
    );
  end

  always_comb begin
    bus.cnt_o = '0;
    req       = '0;
    for (int i = 0; i < N; i++) begin
      bus.cnt_o[i*CNT_W +: CNT_W] = cnt_lane[i];
      req[i]                      = (cnt_lane[i] != '0);
    end
  end

  assign multi_gnt = !onehot0_check(bus.gnt_i);

  // Lanes still retire on a multi-hot grant; the error is only flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_err_q <= 1'b0;
    end else if (multi_gnt || (|bad_gnt)) begin
      gnt_err_q <= 1'b1;
    end
  end

  assign bus.req_o      = req;
  assign bus.full_o     = full;
  assign bus.overflow_o = overflow;
  assign bus.gnt_err_o  = gnt_err_q;
  assign bus.idle_o     = ~|req;

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Per-requestor pending-request tracker that sits directly upstream of single_cycle_arbiter.
- Each requestor pulses push_i once per transaction. The block counts outstanding transactions per lane and drives req_o[k] high while lane k has any pending work.
- Each arbiter grant on gnt_i retires one transaction from that lane, so bursts from one requestor are not lost between grants.

Parameters:
- N, 16: number of requestor lanes; must match the arbiter's N.
- CNT_W, 4: width of each pending counter; maximum depth per lane is 2^CNT_W-1 (15).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- push_i  input  N  bit k = one new request for lane k this cycle.
- gnt_i  input  N  grant from the arbiter; one-hot or zero expected.
- req_o  output  N  request vector to the arbiter; bit k = (cnt[k] != 0).
- full_o  output  N  bit k = cnt[k] at maximum.
- cnt_o  output  N*CNT_W  flattened pending counts; lane k in bits [k*CNT_W +: CNT_W].
- overflow_o  output  N  sticky; lane k dropped a push.
- gnt_err_o  output  1  sticky; illegal grant seen.
- idle_o  output  1  all counters zero.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release on clk):
  - All counters = 0, so req_o=0, full_o=0, cnt_o=0, idle_o=1.
  - overflow_o=0, gnt_err_o=0.
- Per lane k, per rising edge (lanes fully independent). Definitions:
  - inc = push_i[k] and accepted.
  - dec = gnt_i[k] and cnt[k] != 0.
  - Update table:
    - inc and not dec: cnt+1.
    - dec and not inc: cnt-1.
    - both, or neither: cnt unchanged.
- Push acceptance:
  - A push is accepted unless cnt[k] is at maximum and dec=0.
  - Push while full with a simultaneous grant on the same lane: accepted; count stays at maximum.
  - Push while full without a grant: dropped, count unchanged, overflow_o[k] set to 1. overflow_o[k] stays 1 until reset.
- Latency and outputs:
  - All outputs are decoded from registered counters; there are no combinational paths from any input to any output.
  - Push-to-req latency: push at edge t produces req_o[k]=1 visible after edge t (1 cycle).
  - Grant on a lane with cnt=1: req_o[k] falls after the same edge, so the arbiter sees no stale request next cycle.
- Grant error checks:
  - gnt_i[k]=1 while cnt[k]=0: ignored (no underflow); gnt_err_o set.
  - More than one gnt_i bit set in a cycle: every valid lane is still decremented; gnt_err_o set.
  - gnt_err_o is sticky until reset.
- Counter width: saturating unsigned arithmetic in CNT_W bits; counters never wrap in either direction.
- Reset asserted mid-operation: all pending work is discarded immediately (asynchronous); no partial state survives.
- idle_o = 1 when all counters are zero, i.e. the NOR of req_o.

Decomposition:
- Package arb_pkg:
  - Default constants ARB_N=16 and ARB_CNT_W=4, shared with single_cycle_arbiter instantiations.
  - Function onehot0_check(vec), returning 1 if zero or one bit is set.
- Sub-module arb_req_counter: one lane.
  - Ports: clk, reset, push, gnt, cnt, full, overflow, bad_gnt.
  - Instantiated N times via generate.
  - The top level does the multi-hot check, the OR-reduction for gnt_err_o and the idle_o NOR.

Test Plan:
- Reset release with no activity:
  - req_o=0, cnt_o=0, idle_o=1, overflow_o=0, gnt_err_o=0.
- Single push on lane 3:
  - push_i=16'h0008 for 1 cycle gives req_o=16'h0008 and cnt[3]=1 the next cycle.
  - gnt_i=16'h0008 for 1 cycle then gives req_o=0 and idle_o=1.
- Burst then drain:
  - 5 consecutive pushes on lane 0 give cnt[0]=5.
  - 5 one-cycle grants on lane 0 step cnt[0] through 4,3,2,1,0; req_o[0] drops after the 5th grant.
- Saturation on lane 7:
  - 15 pushes give full_o[7]=1.
  - A 16th push with no grant: cnt stays 15 and overflow_o[7]=1.
  - A push plus grant in the same cycle: cnt stays 15, no new overflow.
- Illegal grants:
  - gnt_i=16'h0010 with cnt[4]=0: cnt unchanged, gnt_err_o=1.
  - After a reset, gnt_i=16'h0003 with lanes 0 and 1 at cnt=1: both drop to 0, gnt_err_o=1.
- Closed loop with single_cycle_arbiter (N=16):
  - Apply 10 random push_i vectors, then let the arbiter drain.
  - Total grants counted = total accepted pushes; bench checks idle_o=1 at the end.
  - Assert reset low mid-burst: all outputs return to reset values in the same cycle.
